// File: rtl/mem_writeback_pkg.sv
// Shared encodings for the memory/write-back stage: result select,
// load funct3 values and the stage state machine.
package mem_writeback_pkg;

  // Write-back source select (3 is reserved and behaves like WB_ALU)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Load width/sign encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Stage state: the state itself doubles as the stage-register valid bit
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the byte/halfword lane out of a word-aligned
// read and extends it; flags misaligned accesses and illegal funct3.
module load_align
  import mem_writeback_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Width/sign selection and alignment check
  always_comb begin
    data  = 32'd0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU: data = {24'd0, lane_byte};
      F3_LH: begin
        data  = {{16{lane_half[15]}}, lane_half};
        fault = addr_lo[0];
      end
      F3_LHU: begin
        data  = {16'd0, lane_half};
        fault = addr_lo[0];
      end
      F3_LW: begin
        data  = rdata;
        fault = (addr_lo != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Final pipeline stage: registers execute outputs, completes loads against
// a variable-latency memory and drives the register-file write port.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_result,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_pc,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_is_load,
  input  logic [1:0]       ex_wb_sel,
  input  logic [2:0]       ex_funct3,
  input  logic             dmem_resp_valid,
  input  logic [31:0]      dmem_rdata,
  output logic             stall,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             load_fault,
  output logic             spurious_resp,
  output logic [CNT_W-1:0] stall_cycles
);

  wb_state_t        state_reg;
  logic [31:0]      result_reg;
  logic [31:0]      pc_reg;
  logic [1:0]       addr_lo_reg;
  logic [4:0]       rd_reg;
  logic             reg_we_reg;
  logic [1:0]       wb_sel_reg;
  logic [2:0]       funct3_reg;
  logic [4:0]       last_rd_reg;
  logic [31:0]      last_data_reg;
  logic             spurious_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [31:0] load_data;
  logic        align_fault;
  logic        resp_now;
  logic        we_now;
  logic [31:0] data_now;

  // Only the byte lane of the address matters once the word has been read
  logic unused_addr_bits;
  assign unused_addr_bits = ^ex_addr[31:2];

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_reg),
    .funct3  (funct3_reg),
    .data    (load_data),
    .fault   (align_fault)
  );

  // Write-port and stall decode from the held instruction and memory response
  always_comb begin
    resp_now   = (state_reg == ST_WAIT) && dmem_resp_valid;
    stall      = (state_reg == ST_WAIT) && !dmem_resp_valid;
    load_fault = resp_now && align_fault;
    we_now     = 1'b0;
    data_now   = (wb_sel_reg == WB_PC4) ? pc_reg + 32'd4 : result_reg;
    case (state_reg)
      ST_HOLD: we_now = reg_we_reg && (rd_reg != 5'd0);
      ST_WAIT: begin
        we_now   = resp_now && reg_we_reg && (rd_reg != 5'd0) && !align_fault;
        data_now = load_data;
      end
      default: we_now = 1'b0;
    endcase
  end

  // rd/data keep showing the last write while no write is happening
  assign wb_we         = we_now;
  assign wb_rd         = we_now ? rd_reg : last_rd_reg;
  assign wb_data       = we_now ? data_now : last_data_reg;
  assign spurious_resp = spurious_reg;
  assign stall_cycles  = stall_cnt_reg;

  // Stage register and state: capture a new instruction whenever not stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      result_reg  <= 32'd0;
      pc_reg      <= 32'd0;
      addr_lo_reg <= 2'd0;
      rd_reg      <= 5'd0;
      reg_we_reg  <= 1'b0;
      wb_sel_reg  <= WB_ALU;
      funct3_reg  <= F3_LB;
    end else if (!stall) begin
      result_reg  <= ex_result;
      pc_reg      <= ex_pc;
      addr_lo_reg <= ex_addr[1:0];
      rd_reg      <= ex_rd;
      reg_we_reg  <= ex_reg_we;
      wb_sel_reg  <= ex_wb_sel;
      funct3_reg  <= ex_funct3;
      if (!ex_valid)
        state_reg <= ST_EMPTY;
      else if (ex_is_load)
        state_reg <= ST_WAIT;
      else
        state_reg <= ST_HOLD;
    end
  end

  // Remember the most recent register-file write
  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_reg   <= 5'd0;
      last_data_reg <= 32'd0;
    end else if (we_now) begin
      last_rd_reg   <= rd_reg;
      last_data_reg <= data_now;
    end
  end

  // Sticky flag for a response with no load outstanding
  always_ff @(posedge clk) begin
    if (rst)
      spurious_reg <= 1'b0;
    else if (dmem_resp_valid && (state_reg != ST_WAIT))
      spurious_reg <= 1'b1;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (stall && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed and randomized ALU, link
// and load transactions against a transaction-level reference model.
module tb_mem_writeback;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [31:0]   ex_result;
  logic [31:0]   ex_addr;
  logic [31:0]   ex_pc;
  logic [4:0]    ex_rd;
  logic          ex_reg_we;
  logic          ex_is_load;
  logic [1:0]    ex_wb_sel;
  logic [2:0]    ex_funct3;
  logic          dmem_resp_valid;
  logic [31:0]   dmem_rdata;
  logic          stall;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          load_fault;
  logic          spurious_resp;
  logic [CW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model: last register-file write and stall-cycle total
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_stall;

  mem_writeback #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_result       (ex_result),
    .ex_addr         (ex_addr),
    .ex_pc           (ex_pc),
    .ex_rd           (ex_rd),
    .ex_reg_we       (ex_reg_we),
    .ex_is_load      (ex_is_load),
    .ex_wb_sel       (ex_wb_sel),
    .ex_funct3       (ex_funct3),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .stall           (stall),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .load_fault      (load_fault),
    .spurious_resp   (spurious_resp),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  // Value a load should return, from the width/sign rules
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    int          s;
    b = (w >> (a[1:0] * 8)) & 32'hFF;
    h = (w >> (a[1] * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    begin s = (b >= 32'h80) ? int'(b) - 256 : int'(b); return s; end
      3'd4:    return b;
      3'd1:    begin s = (h >= 32'h8000) ? int'(h) - 65536 : int'(h); return s; end
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_fault(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic set_ex(input logic v, input logic [31:0] res, input logic [31:0] addr,
                        input logic [31:0] pc, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [1:0] sel, input logic [2:0] f3);
    ex_valid = v; ex_result = res; ex_addr = addr; ex_pc = pc; ex_rd = rd;
    ex_reg_we = we; ex_is_load = ld; ex_wb_sel = sel; ex_funct3 = f3;
  endtask

  task automatic bubble();
    set_ex(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 3'd0);
  endtask

  // One non-load instruction: issue, then check the write the next cycle
  task automatic alu_txn(input logic [31:0] res, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic [1:0] sel);
    logic [31:0] exp_d;
    bit          exp_we;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    set_ex(1'b1, res, 32'd0, pc, rd, we, 1'b0, sel, 3'd0);
    @(negedge clk);
    bubble();
    #1;
    exp_we = we && (rd != 0);
    exp_d  = (sel == 2'd2) ? pc + 32'd4 : res;
    if (exp_we) begin m_rd = rd; m_data = exp_d; end
    $display("txn alu sel=%0d rd=%0d we=%0b res=%h pc=%h -> wb_we=%0b wb_data=%h",
             sel, rd, we, res, pc, wb_we, wb_data);
    checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL alu_we got=%0b exp=%0b", wb_we, exp_we); end
    checks++; if (wb_rd !== m_rd) begin errors++; $display("FAIL alu_rd got=%0d exp=%0d", wb_rd, m_rd); end
    checks++; if (wb_data !== m_data) begin errors++; $display("FAIL alu_data got=%h exp=%h", wb_data, m_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%0b exp=0", stall); end
  endtask

  // One load with response lat cycles after capture (lat >= 1)
  task automatic load_txn(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic we, input logic [31:0] rdata, input int lat);
    bit          exp_f;
    bit          exp_we;
    logic [31:0] exp_d;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    set_ex(1'b1, $urandom, addr, $urandom, rd, we, 1'b1, 2'd1, f3);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      bubble();
      #1;
      checks++;
      if ({stall, wb_we} !== 2'b10) begin
        errors++; $display("FAIL load_wait stall/we got=%b exp=10", {stall, wb_we});
      end
      m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end
    @(negedge clk);
    bubble();
    dmem_resp_valid = 1'b1;
    dmem_rdata = rdata;
    #1;
    exp_f  = ref_fault(addr, f3);
    exp_we = we && (rd != 0) && !exp_f;
    exp_d  = ref_load(rdata, addr, f3);
    if (exp_we) begin m_rd = rd; m_data = exp_d; end
    $display("txn load f3=%0d addr=%h rdata=%h lat=%0d rd=%0d -> wb_we=%0b wb_data=%h fault=%0b",
             f3, addr, rdata, lat, rd, wb_we, wb_data, load_fault);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_resp_stall got=%0b exp=0", stall); end
    checks++; if (wb_we !== exp_we) begin errors++; $display("FAIL load_we got=%0b exp=%0b", wb_we, exp_we); end
    checks++; if (wb_rd !== m_rd) begin errors++; $display("FAIL load_rd got=%0d exp=%0d", wb_rd, m_rd); end
    checks++; if (wb_data !== m_data) begin errors++; $display("FAIL load_data got=%h exp=%h", wb_data, m_data); end
    checks++; if (load_fault !== exp_f) begin errors++; $display("FAIL load_fault got=%0b exp=%0b", load_fault, exp_f); end
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    #1;
    checks++; if (load_fault !== 1'b0) begin errors++; $display("FAIL fault_pulse got=%0b exp=0", load_fault); end
    checks++; if (int'(stall_cycles) !== m_stall) begin errors++; $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, m_stall); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bubble();
    dmem_resp_valid = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    m_rd = 5'd0; m_data = 32'd0; m_stall = 0;
    $display("txn reset -> stall=%0b wb_we=%0b wb_rd=%0d wb_data=%h", stall, wb_we, wb_rd, wb_data);
    checks++; if ({stall, wb_we, load_fault, spurious_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {stall, wb_we, load_fault, spurious_resp});
    end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_loads_directed();
    load_txn(32'h0000_1003, 3'd0, 5'd4, 1'b1, 32'h80FF_0000, 3);
    load_txn(32'h0000_1002, 3'd5, 5'd6, 1'b1, 32'hBEEF_0000, 2);
    load_txn(32'h0000_1001, 3'd1, 5'd8, 1'b1, 32'hBEEF_0000, 2);
    load_txn(32'h0000_1004, 3'd3, 5'd9, 1'b1, 32'h1234_5678, 1);
  endtask

  task automatic test_alu();
    alu_txn(32'h0000_1234, 32'h0000_0100, 5'd5, 1'b1, 2'd0);
    alu_txn(32'hCAFE_0001, 32'h0000_0200, 5'd10, 1'b1, 2'd3);
    alu_txn(32'h5555_AAAA, 32'h0000_0300, 5'd11, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++)
      alu_txn($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_jal();
    alu_txn(32'h0000_0000, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2);
    alu_txn(32'h0000_0000, 32'hFFFF_FFFC, 5'd0, 1'b1, 2'd2);
  endtask

  task automatic test_loads_random();
    logic [2:0] f3s[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    for (int i = 0; i < 30; i++)
      load_txn($urandom, f3s[$urandom_range(0, 6)], 5'($urandom_range(0, 31)), 1'($urandom),
               $urandom, $urandom_range(1, 4));
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdata;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      rdata = $urandom;
      res   = $urandom;
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      set_ex(1'b1, 32'd0, 32'h0000_2000 + 32'(i * 4), 32'd0, 5'd7, 1'b1, 1'b1, 2'd1, 3'd2);
      @(negedge clk);
      dmem_resp_valid = 1'b1;
      dmem_rdata = rdata;
      set_ex(1'b1, res, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0, 2'd0, 3'd0);
      #1;
      m_rd = 5'd7; m_data = rdata;
      $display("txn b2b lw rdata=%h then alu res=%h -> wb_we=%0b wb_rd=%0d wb_data=%h",
               rdata, res, wb_we, wb_rd, wb_data);
      checks++; if ({stall, wb_we, wb_rd} !== {2'b01, 5'd7}) begin
        errors++; $display("FAIL b2b_load stall/we/rd got=%b exp=%b", {stall, wb_we, wb_rd}, {2'b01, 5'd7});
      end
      checks++; if (wb_data !== m_data) begin errors++; $display("FAIL b2b_load_data got=%h exp=%h", wb_data, m_data); end
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      bubble();
      #1;
      m_rd = 5'd9; m_data = res;
      checks++; if ({wb_we, wb_rd} !== {1'b1, 5'd9}) begin
        errors++; $display("FAIL b2b_alu we/rd got=%b exp=%b", {wb_we, wb_rd}, {1'b1, 5'd9});
      end
      checks++; if (wb_data !== m_data) begin errors++; $display("FAIL b2b_alu_data got=%h exp=%h", wb_data, m_data); end
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bubble();
    #1;
    checks++; if (spurious_resp !== 1'b0) begin errors++; $display("FAIL spur_before got=%0b exp=0", spurious_resp); end
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL spur_we got=%0b exp=0", wb_we); end
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    #1;
    $display("txn spurious pulse in EMPTY -> spurious_resp=%0b", spurious_resp);
    checks++; if (spurious_resp !== 1'b1) begin errors++; $display("FAIL spur_set got=%0b exp=1", spurious_resp); end
    alu_txn(32'h0000_0042, 32'd0, 5'd3, 1'b1, 2'd0);
    checks++; if (spurious_resp !== 1'b1) begin errors++; $display("FAIL spur_sticky got=%0b exp=1", spurious_resp); end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    set_ex(1'b1, 32'd0, 32'h0000_3000, 32'd0, 5'd3, 1'b1, 1'b1, 2'd1, 3'd0);
    @(negedge clk);
    bubble();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_stall_before got=%0b exp=1", stall); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_rd = 5'd0; m_data = 32'd0; m_stall = 0;
    $display("txn reset in WAIT -> stall=%0b wb_we=%0b stall_cycles=%0d", stall, wb_we, stall_cycles);
    checks++; if ({stall, wb_we, spurious_resp} !== 3'b000) begin
      errors++; $display("FAIL rw_after got=%b exp=000", {stall, wb_we, spurious_resp});
    end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL rw_cnt got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h0000_0077;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rw_late_we got=%0b exp=0", wb_we); end
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    #1;
    checks++; if (spurious_resp !== 1'b1) begin errors++; $display("FAIL rw_spur got=%0b exp=1", spurious_resp); end
    checks++; if (wb_data !== m_data) begin errors++; $display("FAIL rw_data got=%h exp=%h", wb_data, m_data); end
  endtask

  initial begin
    test_reset();
    test_loads_directed();
    test_alu();
    test_jal();
    test_loads_random();
    test_back_to_back();
    test_spurious();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Final pipeline stage, directly downstream of the execute stage. Registers execute outputs and completes loads against a variable-latency data memory.
- Aligns and extends load data, then drives the register-file write port.
- Produces the `previous` value and `prev_rd`/`prev_reg_we` that execute uses for forwarding.
- Raises `stall` to freeze upstream stages while a load response is outstanding.

Parameters:
- CNT_W, 32, width of the load-stall performance counter (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  execute holds a valid instruction
- ex_result  input  32  ALU result
- ex_addr  input  32  full byte address (forwarded rs1 + imm) of load/store
- ex_pc  input  32  PC of instruction; pc+4 used for jal/jalr link
- ex_rd  input  5  destination register
- ex_reg_we  input  1  instruction writes rd
- ex_is_load  input  1  instruction is a load
- ex_wb_sel  input  2  0=ALU result, 1=load data, 2=pc+4, 3=reserved (treated as 0)
- ex_funct3  input  3  load width/sign
- dmem_resp_valid  input  1  load data valid this cycle
- dmem_rdata  input  32  word-aligned read data
- stall  output  1  hold upstream stages and keep ex_* stable
- wb_we  output  1  register-file write enable (also prev_reg_we)
- wb_rd  output  5  write address (also prev_rd)
- wb_data  output  32  write data (also previous)
- load_fault  output  1  one-cycle pulse on misaligned or illegal-funct3 load
- spurious_resp  output  1  sticky flag; set when a response arrives outside WAIT
- stall_cycles  output  CNT_W  count of cycles with stall=1, saturating at all-ones

Behaviour:
- Reset state:
  - state=EMPTY, stage register valid=0, stall=0, wb_we=0, wb_rd=0, wb_data=0.
  - load_fault=0, spurious_resp=0, stall_cycles=0.
  - Reset applied mid-WAIT abandons the load; a later response counts as spurious.
- States:
  - EMPTY: no valid instruction held.
  - HOLD: non-load held; write-back this cycle.
  - WAIT: load held, response pending.
- Capture:
  - When stall=0, the stage register loads all ex_* fields on the edge.
  - Next state: EMPTY if ex_valid=0; WAIT if ex_is_load=1; otherwise HOLD.
  - When stall=1, the stage register holds its value.
- HOLD:
  - wb_we = reg_we && rd!=0.
  - wb_data selected by wb_sel: ALU result or pc+4 (32-bit wrap).
  - stall=0.
- WAIT:
  - stall = !dmem_resp_valid, combinationally.
  - In the response cycle: wb_we = reg_we && rd!=0 && !fault; wb_data = aligned load; stall=0; the next instruction is captured on that edge.
  - Response latency: at least 1 cycle after capture, unbounded.
- Load alignment: the byte lane is addr[1:0].
  - LB: sign-extend lane byte. LBU: zero-extend lane byte.
  - LH: sign-extend halfword at addr[1]*16. LHU: zero-extend that halfword.
  - LW: the full word.
- Fault:
  - Conditions: LH/LHU with addr[0]=1; LW with addr[1:0]!=0; funct3 in {011,110,111}.
  - The fault is detected at capture. The load still waits for its response so the memory handshake completes.
  - In the response cycle: load_fault=1, write suppressed.
- Output rules:
  - wb_we=0 in EMPTY and whenever stall=1.
  - wb_rd and wb_data hold their last values when wb_we=0.
- Boundaries:
  - Back-to-back loads: the second is captured in the first's response cycle. No bubble is required.
  - dmem_resp_valid in EMPTY or HOLD: ignored for write-back; spurious_resp set until rst.
  - stall_cycles increments every cycle stall=1 and does not wrap.
  - Reserved wb_sel (3) writes the ALU result.

Decomposition:
- Shared package holds:
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State encoding (ST_EMPTY, ST_HOLD, ST_WAIT).
- One combinational sub-module, load_align: inputs rdata, addr[1:0] and funct3; outputs data and fault.
- The state machine, stage register, counter and flags stay in mem_writeback.

Test Plan:
- ALU op: ex_valid=1, wb_sel=0, ex_result=0x0000_1234, rd=5, reg_we=1 → next cycle wb_we=1, wb_rd=5, wb_data=0x1234, stall=0.
- Jal link: ex_pc=0xFFFF_FFFC, wb_sel=2, rd=1 → wb_data=0x0000_0000 (wrap); same instruction with rd=0 → wb_we=0.
- LB, 3-cycle memory: addr=0x1003, rdata=0x80FF_0000 → stall=1 for 2 cycles, stall_cycles=2; response cycle wb_data=0xFFFF_FF80, wb_we=1.
- LHU at addr=0x1002 with rdata=0xBEEF_0000 → wb_data=0x0000_BEEF. LH at addr=0x1001 → load_fault pulse, wb_we=0, stall released on the response.
- Back-to-back: LW (response after 1 cycle) then an ALU op → the ALU write lands the cycle after the load write, with no bubble. A dmem_resp_valid pulse while EMPTY → spurious_resp=1 and stays set.
- Reset during WAIT (stall=1) → next cycle stall=0, wb_we=0, stall_cycles=0. A response arriving afterwards sets spurious_resp and causes no write.
